// File: rtl/debug_panel.sv
// debug_panel
//   Board debug front end. Raw push-buttons are polarity-normalised,
//   synchronised and debounced. Buttons 0 (NEXT) and 1 (PREV) feed gesture
//   FSMs that produce click and long-press pulses, which step, home or freeze
//   a page selector. Holding NEXT and PREV together raises a chord reset
//   request. The selected page word is shown only after it has held steady.
//
// Ports
//   clk          system clock
//   i_reset_n    asynchronous active-low reset
//   i_buttons    raw button pins (asynchronous)
//   i_pages      unpacked array of N_PAGES page words
//   o_buttons    debounced levels, 1 = pressed
//   o_click      one-cycle click pulses   [0] NEXT, [1] PREV
//   o_long       one-cycle long pulses    [0] NEXT, [1] PREV
//   o_page_idx   current page index
//   o_frozen     display frozen
//   o_page_data  stabilised displayed word
//   o_reset      chord reset request, active-high
module debug_panel #(
    parameter int N_BUTTONS          = 2,
    parameter int WIDTH              = 8,
    parameter int N_PAGES            = 4,
    parameter int ACTIVE_LOW_BUTTONS = 1,
    parameter int DEADZONE_CYCLES    = 1024,
    parameter int LONG_CYCLES        = 25000000,
    parameter int CHORD_CYCLES       = 50000000,
    parameter int HOLD_CYCLES        = 52428800
) (
    input  logic                       clk,
    input  logic                       i_reset_n,
    input  logic [N_BUTTONS-1:0]       i_buttons,
    input  logic [WIDTH-1:0]           i_pages [N_PAGES],
    output logic [N_BUTTONS-1:0]       o_buttons,
    output logic [1:0]                 o_click,
    output logic [1:0]                 o_long,
    output logic [$clog2(N_PAGES)-1:0] o_page_idx,
    output logic                       o_frozen,
    output logic [WIDTH-1:0]           o_page_data,
    output logic                       o_reset
);

    localparam int IDX_W   = $clog2(N_PAGES);
    localparam int DB_W    = $clog2(DEADZONE_CYCLES + 32'sd1);
    localparam int LONG_W  = $clog2(LONG_CYCLES + 32'sd1);
    localparam int CHORD_W = $clog2(CHORD_CYCLES + 32'sd1);
    localparam int HOLD_W  = $clog2(HOLD_CYCLES + 32'sd1);

    localparam logic [DB_W-1:0]    DB_ZERO    = {DB_W{1'b0}};
    localparam logic [DB_W-1:0]    DB_ONE     = DB_W'(1'b1);
    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEADZONE_CYCLES - 32'sd1);
    localparam logic [LONG_W-1:0]  LONG_ZERO  = {LONG_W{1'b0}};
    localparam logic [LONG_W-1:0]  LONG_ONE   = LONG_W'(1'b1);
    localparam logic [LONG_W-1:0]  LONG_MAX   = LONG_W'(LONG_CYCLES);
    localparam logic [CHORD_W-1:0] CHORD_ZERO = {CHORD_W{1'b0}};
    localparam logic [CHORD_W-1:0] CHORD_ONE  = CHORD_W'(1'b1);
    localparam logic [CHORD_W-1:0] CHORD_MAX  = CHORD_W'(CHORD_CYCLES);
    localparam logic [CHORD_W-1:0] CHORD_LAST = CHORD_W'(CHORD_CYCLES - 32'sd1);
    localparam logic [HOLD_W-1:0]  HOLD_ZERO  = {HOLD_W{1'b0}};
    localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1'b1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 32'sd1);
    localparam logic [IDX_W-1:0]   IDX_ZERO   = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1'b1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_PAGES - 32'sd1);

    typedef enum logic [1:0] {
        G_IDLE       = 2'd0,
        G_PRESSED    = 2'd1,
        G_LONGHELD   = 2'd2,
        G_SUPPRESSED = 2'd3
    } gest_state_t;

    // Input path and debounce
    logic [N_BUTTONS-1:0] norm_s;
    logic [N_BUTTONS-1:0] sync1_r;
    logic [N_BUTTONS-1:0] sync2_r;
    logic [N_BUTTONS-1:0] db_r;
    logic [DB_W-1:0]      db_cnt_r [N_BUTTONS];

    // Chord
    logic                 both_s;
    logic                 chord_fire_s;
    logic [CHORD_W-1:0]   chord_cnt_r;
    logic                 reset_r;

    // Gestures
    gest_state_t          st_r   [2];
    gest_state_t          st_s   [2];
    logic [LONG_W-1:0]    hold_r [2];
    logic [LONG_W-1:0]    hold_s [2];
    logic [1:0]           click_s;
    logic [1:0]           long_s;
    logic [1:0]           click_r;
    logic [1:0]           long_r;

    // Page selection and stabiliser
    logic [IDX_W-1:0]     idx_s;
    logic [IDX_W-1:0]     idx_r;
    logic                 frozen_r;
    logic [WIDTH-1:0]     captured_r;
    logic [WIDTH-1:0]     cand_s;
    logic                 same_s;
    logic [WIDTH-1:0]     prev_cand_r;
    logic [HOLD_W-1:0]    stab_cnt_r;
    logic [WIDTH-1:0]     page_data_r;

    // Normalise button polarity so that 1 always means pressed.
    always_comb begin
        if (ACTIVE_LOW_BUTTONS != 32'sd0) begin
            norm_s = ~i_buttons;
        end else begin
            norm_s = i_buttons;
        end
    end

    // Two-flop synchroniser plus per-button debounce counter.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1_r <= {N_BUTTONS{1'b0}};
            sync2_r <= {N_BUTTONS{1'b0}};
            db_r    <= {N_BUTTONS{1'b0}};
            for (int b = 32'sd0; b < N_BUTTONS; b++) begin
                db_cnt_r[b] <= DB_ZERO;
            end
        end else begin
            sync1_r <= norm_s;
            sync2_r <= sync1_r;
            for (int b = 32'sd0; b < N_BUTTONS; b++) begin
                if (sync2_r[b] != db_r[b]) begin
                    // The flip happens on the DEADZONE-th consecutive disagreeing cycle.
                    if (db_cnt_r[b] == DB_LAST) begin
                        db_r[b]     <= sync2_r[b];
                        db_cnt_r[b] <= DB_ZERO;
                    end else begin
                        db_cnt_r[b] <= db_cnt_r[b] + DB_ONE;
                    end
                end else begin
                    db_cnt_r[b] <= DB_ZERO;
                end
            end
        end
    end

    // Chord qualifiers: fire on the cycle the hold count reaches CHORD_CYCLES.
    always_comb begin
        both_s       = db_r[0] & db_r[1];
        chord_fire_s = both_s && (chord_cnt_r == CHORD_LAST);
    end

    // Chord hold counter (saturating) and registered reset request.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            chord_cnt_r <= CHORD_ZERO;
            reset_r     <= 1'b0;
        end else begin
            if (both_s) begin
                if (chord_cnt_r != CHORD_MAX) begin
                    chord_cnt_r <= chord_cnt_r + CHORD_ONE;
                end else begin
                    chord_cnt_r <= chord_cnt_r;
                end
            end else begin
                chord_cnt_r <= CHORD_ZERO;
            end
            // High from the cycle the count reaches the limit while both stay held.
            reset_r <= both_s && (chord_cnt_r >= CHORD_LAST);
        end
    end

    // Gesture FSM next-state and event decode for NEXT (0) and PREV (1).
    always_comb begin
        for (int g = 32'sd0; g < 32'sd2; g++) begin
            st_s[g]    = st_r[g];
            hold_s[g]  = hold_r[g];
            click_s[g] = 1'b0;
            long_s[g]  = 1'b0;
            if (chord_fire_s) begin
                st_s[g]   = G_SUPPRESSED;
                hold_s[g] = LONG_ZERO;
            end else begin
                case (st_r[g])
                    G_IDLE: begin
                        if (db_r[g]) begin
                            st_s[g]   = G_PRESSED;
                            hold_s[g] = LONG_ZERO;
                        end else begin
                            st_s[g] = G_IDLE;
                        end
                    end
                    G_PRESSED: begin
                        if (!db_r[g]) begin
                            click_s[g] = 1'b1;
                            st_s[g]    = G_IDLE;
                        end else if (hold_r[g] == LONG_MAX) begin
                            long_s[g] = 1'b1;
                            st_s[g]   = G_LONGHELD;
                        end else begin
                            hold_s[g] = hold_r[g] + LONG_ONE;
                        end
                    end
                    G_LONGHELD, G_SUPPRESSED: begin
                        if (!db_r[g]) begin
                            st_s[g] = G_IDLE;
                        end else begin
                            st_s[g] = st_r[g];
                        end
                    end
                    default: begin
                        st_s[g] = G_IDLE;
                    end
                endcase
            end
        end
    end

    // Gesture FSM state, hold counters and registered event pulses.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int g = 32'sd0; g < 32'sd2; g++) begin
                st_r[g]   <= G_IDLE;
                hold_r[g] <= LONG_ZERO;
            end
            click_r <= 2'b00;
            long_r  <= 2'b00;
        end else begin
            for (int g = 32'sd0; g < 32'sd2; g++) begin
                st_r[g]   <= st_s[g];
                hold_r[g] <= hold_s[g];
            end
            click_r <= click_s;
            long_r  <= long_s;
        end
    end

    // Page index update from the previous cycle's events; home beats clicks.
    always_comb begin
        idx_s = idx_r;
        if (long_r[1]) begin
            idx_s = IDX_ZERO;
        end else if (click_r[0] && !click_r[1]) begin
            if (idx_r == IDX_LAST) begin
                idx_s = IDX_ZERO;
            end else begin
                idx_s = idx_r + IDX_ONE;
            end
        end else if (click_r[1] && !click_r[0]) begin
            if (idx_r == IDX_ZERO) begin
                idx_s = IDX_LAST;
            end else begin
                idx_s = idx_r - IDX_ONE;
            end
        end else begin
            idx_s = idx_r;
        end
    end

    // Page index, freeze toggle and snapshot of the display on freeze.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            idx_r      <= IDX_ZERO;
            frozen_r   <= 1'b0;
            captured_r <= {WIDTH{1'b0}};
        end else begin
            idx_r    <= idx_s;
            frozen_r <= frozen_r ^ long_r[0];
            if (long_r[0] && !frozen_r) begin
                captured_r <= page_data_r;
            end else begin
                captured_r <= captured_r;
            end
        end
    end

    // Candidate display word and its cycle-to-cycle stability.
    always_comb begin
        if (frozen_r) begin
            cand_s = captured_r;
        end else begin
            cand_s = i_pages[idx_r];
        end
        same_s = (cand_s == prev_cand_r);
    end

    // Stabiliser: load the display once the candidate has held for HOLD_CYCLES.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            prev_cand_r <= {WIDTH{1'b0}};
            stab_cnt_r  <= HOLD_ZERO;
            page_data_r <= {WIDTH{1'b0}};
        end else begin
            prev_cand_r <= cand_s;
            if (!same_s) begin
                stab_cnt_r <= HOLD_ZERO;
            end else if (stab_cnt_r != HOLD_MAX) begin
                stab_cnt_r <= stab_cnt_r + HOLD_ONE;
            end else begin
                stab_cnt_r <= stab_cnt_r;
            end
            if (same_s && (stab_cnt_r >= HOLD_LAST)) begin
                page_data_r <= cand_s;
            end else begin
                page_data_r <= page_data_r;
            end
        end
    end

    assign o_buttons   = db_r;
    assign o_click     = click_r;
    assign o_long      = long_r;
    assign o_page_idx  = idx_r;
    assign o_frozen    = frozen_r;
    assign o_page_data = page_data_r;
    assign o_reset     = reset_r;

endmodule

// File: tb/tb_debug_panel.sv
// Self-checking bench for debug_panel: directed scenarios followed by a
// randomized phase, every cycle compared against a reference model that
// works from sample histories and timestamps.
module tb_debug_panel;

    localparam int NB = 3;
    localparam int W  = 8;
    localparam int NP = 3;
    localparam int DZ = 4;
    localparam int LG = 20;
    localparam int CH = 10;
    localparam int HD = 3;

    logic          clk = 1'b0;
    logic          i_reset_n;
    logic [NB-1:0] i_buttons;
    logic [W-1:0]  pages [NP];
    logic [NB-1:0] o_buttons;
    logic [1:0]    o_click;
    logic [1:0]    o_long;
    logic [1:0]    o_page_idx;
    logic          o_frozen;
    logic [W-1:0]  o_page_data;
    logic          o_reset;

    debug_panel #(
        .N_BUTTONS(NB), .WIDTH(W), .N_PAGES(NP), .ACTIVE_LOW_BUTTONS(0),
        .DEADZONE_CYCLES(DZ), .LONG_CYCLES(LG), .CHORD_CYCLES(CH), .HOLD_CYCLES(HD)
    ) dut (
        .clk(clk), .i_reset_n(i_reset_n), .i_buttons(i_buttons), .i_pages(pages),
        .o_buttons(o_buttons), .o_click(o_click), .o_long(o_long),
        .o_page_idx(o_page_idx), .o_frozen(o_frozen), .o_page_data(o_page_data),
        .o_reset(o_reset)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nerrors = 0;
    int nclick[2];
    int nlong[2];

    // Reference model state
    bit          rh [NB][DZ+2];   // rh[b][k] = raw pin b sampled k edges ago
    bit [NB-1:0] m_db;
    int          both_run;
    bit          m_reset;
    bit [1:0]    in_press, spent, m_click, m_long;
    int          start_t [2];
    int          m_idx;
    bit          m_frozen;
    bit [W-1:0]  m_cap, m_pd;
    int          ch [HD+1];       // ch[k] = candidate word seen k edges ago
    int          t_edge;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        assert (got === exp) else begin
            nerrors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < NB; b++)
            for (int k = 0; k < DZ + 2; k++) rh[b][k] = 1'b0;
        m_db = '0; both_run = 0; m_reset = 1'b0;
        in_press = '0; spent = '0; m_click = '0; m_long = '0;
        start_t[0] = 0; start_t[1] = 0;
        m_idx = 0; m_frozen = 1'b0; m_cap = '0; m_pd = '0;
        ch[0] = 0;
        for (int k = 1; k <= HD; k++) ch[k] = -1;
        t_edge = 0;
    endtask

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic model_edge();
        bit [NB-1:0] db_n;
        bit          both, fire, all_diff, all_eq;
        bit [1:0]    click_n, long_n;
        int          cand;
        if (!i_reset_n) begin
            model_reset();
        end else begin
            t_edge++;
            db_n = m_db;
            for (int b = 0; b < NB; b++) begin
                for (int k = DZ + 1; k > 0; k--) rh[b][k] = rh[b][k-1];
                rh[b][0] = i_buttons[b];
                all_diff = 1'b1;
                for (int k = 2; k <= DZ + 1; k++)
                    if (rh[b][k] == m_db[b]) all_diff = 1'b0;
                if (all_diff) db_n[b] = ~m_db[b];
            end
            both = m_db[0] & m_db[1];
            if (both) both_run++; else both_run = 0;
            fire = both && (both_run == CH);
            click_n = '0; long_n = '0;
            for (int g = 0; g < 2; g++) begin
                if (fire) begin
                    in_press[g] = 1'b1; spent[g] = 1'b1;
                end else if (!in_press[g]) begin
                    if (m_db[g]) begin in_press[g] = 1'b1; start_t[g] = t_edge; spent[g] = 1'b0; end
                end else if (!m_db[g]) begin
                    if (!spent[g]) click_n[g] = 1'b1;
                    in_press[g] = 1'b0;
                end else if (!spent[g] && (t_edge - start_t[g] == LG + 1)) begin
                    long_n[g] = 1'b1; spent[g] = 1'b1;
                end
            end
            cand = m_frozen ? int'(m_cap) : int'(pages[m_idx]);
            for (int k = HD; k > 0; k--) ch[k] = ch[k-1];
            ch[0] = cand;
            all_eq = 1'b1;
            for (int k = 1; k <= HD; k++) if (ch[k] != cand) all_eq = 1'b0;
            if (m_long[0] && !m_frozen) m_cap = m_pd;
            m_frozen = m_frozen ^ m_long[0];
            if (m_long[1]) m_idx = 0;
            else m_idx = (m_idx + int'(m_click[0]) - int'(m_click[1]) + NP) % NP;
            if (all_eq) m_pd = W'(cand);
            m_reset = both && (both_run >= CH);
            m_click = click_n; m_long = long_n; m_db = db_n;
        end
    endtask

    task automatic check_all();
        chk("buttons", 32'(o_buttons), 32'(m_db));
        chk("click", 32'(o_click), 32'(m_click));
        chk("long", 32'(o_long), 32'(m_long));
        chk("page_idx", 32'(o_page_idx), 32'(m_idx));
        chk("frozen", 32'(o_frozen), 32'(m_frozen));
        chk("page_data", 32'(o_page_data), 32'(m_pd));
        chk("reset", 32'(o_reset), 32'(m_reset));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        for (int g = 0; g < 2; g++) begin
            nclick[g] += int'(o_click[g]);
            nlong[g]  += int'(o_long[g]);
        end
    endtask

    task automatic assert_reset();
        i_reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) step();
        i_reset_n = 1'b1;
    endtask

    task automatic press(input int b, input int hold, input int after);
        i_buttons[b] = 1'b1;
        repeat (hold) step();
        i_buttons[b] = 1'b0;
        repeat (after) step();
    endtask

    // Steps until o_buttons[b] == lvl; n = cycles taken, -1 if the bound expires.
    task automatic wait_btn(input int b, input bit lvl, input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound && n < 0; i++) begin
            step();
            if (o_buttons[b] == lvl) n = i;
        end
    endtask

    initial begin
        int n, c0, l0, t_both, t_rst, pidx;
        nclick[0] = 0; nclick[1] = 0; nlong[0] = 0; nlong[1] = 0;
        i_buttons = '0;
        pages[0] = 8'hA0; pages[1] = 8'hB1; pages[2] = 8'hC2;
        i_reset_n = 1'b0;
        #2;
        model_reset();
        check_all();
        repeat (2) step();
        i_reset_n = 1'b1;
        repeat (8) step();
        chk("init_page_data", 32'(o_page_data), 32'h0000_00A0);

        // Reset in the middle of a press, release with the button still held.
        i_buttons[0] = 1'b1;
        repeat (15) step();
        i_reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("async_reset_buttons", 32'(o_buttons), 32'h0);
        chk("async_reset_data", 32'(o_page_data), 32'h0);
        repeat (2) step();
        i_reset_n = 1'b1;
        wait_btn(0, 1'b1, 12, n);
        chk("reset_release_latency", 32'(n), 32'd6);
        i_buttons[0] = 1'b0;
        assert_reset();
        repeat (8) step();

        // Debounce: short glitch ignored, longer pulse passes with fixed latency.
        i_buttons[2] = 1'b1;
        repeat (3) step();
        i_buttons[2] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("glitch_ignored", 32'(o_buttons[2]), 32'h0);
        end
        i_buttons[2] = 1'b1;
        wait_btn(2, 1'b1, 12, n);
        chk("debounce_rise", 32'(n), 32'd6);
        repeat (10 - 6) step();
        i_buttons[2] = 1'b0;
        wait_btn(2, 1'b0, 12, n);
        chk("debounce_fall", 32'(n), 32'd6);
        repeat (2) step();

        // Wrap: three NEXT clicks then one PREV click.
        c0 = nclick[0];
        press(0, 8, 14); chk("next_idx1", 32'(o_page_idx), 32'd1);
        press(0, 8, 14); chk("next_idx2", 32'(o_page_idx), 32'd2);
        press(0, 8, 14); chk("next_wrap0", 32'(o_page_idx), 32'd0);
        chk("next_click_count", 32'(nclick[0] - c0), 32'd3);
        press(1, 8, 14); chk("prev_wrap2", 32'(o_page_idx), 32'd2);
        chk("prev_page_data", 32'(o_page_data), 32'h0000_00C2);

        // Long press freezes; page changes hidden; second long unfreezes.
        c0 = nclick[0]; l0 = nlong[0];
        press(0, 30, 14);
        chk("freeze_long_count", 32'(nlong[0] - l0), 32'd1);
        chk("freeze_no_click", 32'(nclick[0] - c0), 32'd0);
        chk("frozen_set", 32'(o_frozen), 32'd1);
        pages[2] = 8'h3C;
        repeat (10) step();
        chk("frozen_hold", 32'(o_page_data), 32'h0000_00C2);
        press(0, 30, 14);
        chk("frozen_clear", 32'(o_frozen), 32'd0);
        chk("unfrozen_follow", 32'(o_page_data), 32'h0000_003C);

        // Chord: both held, reset asserts CH cycles after both debounced.
        c0 = nclick[0] + nclick[1]; l0 = nlong[0] + nlong[1];
        t_both = -1; t_rst = -1;
        i_buttons[1:0] = 2'b11;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (t_both < 0 && o_buttons[1:0] == 2'b11) t_both = i;
            if (t_rst < 0 && o_reset) t_rst = i;
        end
        i_buttons[1:0] = 2'b00;
        repeat (14) step();
        chk("chord_delay", 32'(t_rst - t_both), 32'd10);
        chk("chord_no_click", 32'(nclick[0] + nclick[1] - c0), 32'd0);
        chk("chord_no_long", 32'(nlong[0] + nlong[1] - l0), 32'd0);
        chk("chord_idx", 32'(o_page_idx), 32'd2);
        chk("chord_released", 32'(o_reset), 32'd0);

        // PREV long goes home, then stabiliser against a toggling page word.
        press(1, 30, 14);
        chk("home_idx", 32'(o_page_idx), 32'd0);
        chk("home_data", 32'(o_page_data), 32'h0000_00A0);
        for (int i = 0; i < 10; i++) begin
            pages[0] = (i % 2 == 0) ? 8'h11 : 8'h22;
            repeat (2) begin
                step();
                chk("toggle_stable", 32'(o_page_data), 32'h0000_00A0);
            end
        end
        pages[0] = 8'h5A;
        repeat (3) step();
        chk("settle_not_yet", 32'(o_page_data), 32'h0000_00A0);
        step();
        chk("settle_5a", 32'(o_page_data), 32'h0000_005A);

        // Randomized phase against the model.
        for (int seg = 0; seg < 60; seg++) begin
            i_buttons = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                pidx = int'($urandom_range(0, NP - 1));
                pages[pidx] = 8'($urandom);
            end
            repeat ($urandom_range(1, 45)) step();
        end
        i_buttons = '0;
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
